// File: rtl/mem_stall_controller.sv
// MEM-stage stall sequencer for variable-latency data memory: holds the upstream
// pipeline, bubbles M/W while an access is outstanding, aborts hung accesses.
module mem_stall_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_MemReadM,
  input  logic                  i_MemWriteM,
  input  logic                  i_MemReadyM,
  input  logic                  i_ErrClr,
  output logic                  o_MemReqM,
  output logic                  o_StallM,
  output logic                  o_BubbleW,
  output logic                  o_TimeoutErr,
  output logic [CNT_WIDTH-1:0]  o_WaitCount,
  output logic [PERF_WIDTH-1:0] o_StallCycles
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ABORT} state_t;

  // Handshake: o_MemReqM stays high from issue until the cycle i_MemReadyM is
  // seen; the memory only completes while the request is high and must accept
  // the request being withdrawn by reset or abort.
  localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT_CYCLES - 2);

  state_t state, state_nx;
  logic   acc;

  assign acc = i_MemReadM | i_MemWriteM;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // The counter still holds the pre-increment value here, so the last wait
  // cycle is the one where it reads TIMEOUT_CYCLES-2.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (acc) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (i_MemReadyM)                   state_nx = ST_IDLE;
        else if (o_WaitCount == LAST_WAIT) state_nx = ST_ABORT;
      end
      ST_ABORT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Gated by reset so the controls read low while reset is held, even with
  // an access still presented in M.
  always_comb begin
    o_MemReqM = 1'b0;
    o_StallM  = 1'b0;
    o_BubbleW = 1'b0;
    case (state)
      ST_IDLE: begin
        o_MemReqM = acc;
        o_StallM  = acc;
        o_BubbleW = acc;
      end
      ST_WAIT: begin
        o_MemReqM = 1'b1;
        o_StallM  = ~i_MemReadyM;
        o_BubbleW = ~i_MemReadyM;
      end
      ST_ABORT: o_BubbleW = 1'b1;
      default: ;
    endcase
    o_MemReqM = o_MemReqM & i_RST;
    o_StallM  = o_StallM  & i_RST;
    o_BubbleW = o_BubbleW & i_RST;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      o_WaitCount <= '0;
    end else if (state == ST_WAIT && !i_MemReadyM) begin
      o_WaitCount <= o_WaitCount + CNT_WIDTH'(1);
    end else begin
      o_WaitCount <= '0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST)                 o_TimeoutErr <= 1'b0;
    else if (state == ST_ABORT) o_TimeoutErr <= 1'b1;
    else if (i_ErrClr)          o_TimeoutErr <= 1'b0;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST)                          o_StallCycles <= '0;
    else if (o_StallM && !(&o_StallCycles)) o_StallCycles <= o_StallCycles + PERF_WIDTH'(1);
  end

endmodule
